axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Parametrised AXI4-Lite master engine that turns single-cycle write/read command pulses into complete AXI4-Lite transactions on independent write and read paths. It extends the command-level interface used by our AXI-Lite test environment (start/addr/data in, done/error out) with configurable widths, byte strobes, concurrent read and write, and an optional hung-slave watchdog. It sits between a local controller (CPU bridge, sequencer or bench driver) and an AXI4-Lite slave or interconnect.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; 32 or 64 only
- TIMEOUT_CYCLES, 256, watchdog limit in cycles; ≥2; used only with AXIL_MASTER_TIMEOUT_EN
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- start_write  in  1  write command pulse; sampled only while w_busy=0
- waddr  in  ADDR_W  write address, captured on start_write
- wdata  in  DATA_W  write data, captured on start_write
- wstrb  in  DATA_W/8  write byte strobes, captured on start_write
- w_busy  out  1  write path occupied
- w_done  out  1  one-cycle completion pulse
- w_error  out  1  valid with w_done; 1 if BRESP≠OKAY or timeout
- start_read  in  1  read command pulse; sampled only while r_busy=0
- raddr  in  ADDR_W  read address, captured on start_read
- r_busy  out  1  read path occupied
- rdata  out  DATA_W  read data; updated on R handshake, held until next R handshake
- r_done  out  1  one-cycle completion pulse
- r_error  out  1  valid with r_done; 1 if RRESP≠OKAY or timeout
- AW channel: m_awaddr out ADDR_W, m_awvalid out 1, m_awready in 1
- W channel: m_wdata out DATA_W, m_wstrb out DATA_W/8, m_wvalid out 1, m_wready in 1
- B channel: m_bresp in 2, m_bvalid in 1, m_bready out 1
- AR channel: m_araddr out ADDR_W, m_arvalid out 1, m_arready in 1
- R channel: m_rdata in DATA_W, m_rresp in 2, m_rvalid in 1, m_rready out 1

## Operation
- Write FSM: W_IDLE → W_REQ (start_write while idle) → W_RESP (both AW and W handshakes done) → W_IDLE (B handshake; pulse w_done, w_error = bresp≠2'b00).
- W_REQ: m_awvalid and m_wvalid rise together; each drops independently on its own handshake, in either order or the same cycle. Neither valid drops before its ready.
- W_RESP: m_bready=1; m_bready=0 in all other write states.
- Read FSM: R_IDLE → R_ADDR (start_read) → R_DATA (AR handshake; m_rready=1) → R_IDLE (R handshake; latch rdata, pulse r_done, r_error = rresp≠2'b00).
- Read and write paths are fully independent; simultaneous start_write and start_read both accepted in the same cycle.
- start_* while the matching busy=1 is ignored; no queueing, no error flag.
- w_busy=1 in every state except W_IDLE; r_busy likewise.
- Output address/data/strobe registers hold the captured command until the next accepted command.

## Timing
- Reset: all valids, m_bready, m_rready, busy, done, error = 0; m_awaddr, m_wdata, m_wstrb, m_araddr, rdata = 0; FSMs idle. Assertion mid-transaction aborts immediately; no done pulse.
- Edge 0 samples start; m_*valid high after edge 0. Zero-wait slave: AW/W handshake edge 1, B handshake edge 2, w_done high after edge 2 (sampled at edge 3). Read identical: start→r_done sampled 3 edges later.
- Back-to-back: new start accepted on the edge where done is high (busy already 0).

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined: per-path counter clears on state entry and on every handshake; counts while not idle. On reaching TIMEOUT_CYCLES: drop valids, pulse done with error=1, enter a DRAIN state (busy=1, bready/rready=1) that exits on one stray response (discarded, no done) or a second TIMEOUT_CYCLES expiry.
- Undefined: no counter, no DRAIN state; a silent slave stalls the path indefinitely.

## Test plan
- Zero-wait write waddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF -> AW/W at edge 1, w_done at edge 3, w_error=0.
- Write with awready delayed 3 cycles, wready immediate, bresp=2'b10 -> m_wvalid drops first, m_awvalid held 3 cycles, w_done with w_error=1.
- Concurrent start_write and start_read in one cycle; read returns 0x12345678, rresp=0 -> both dones, rdata=0x12345678, no cross-path interference.
- start_read asserted while r_busy=1 -> ignored; exactly one AR handshake and one r_done.
- aresetn low during W_RESP -> all outputs at reset values next cycle, no w_done; fresh write after release completes normally.
- With AXIL_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts arready -> r_done with r_error=1 after 8 cycles; a late rvalid is drained with no r_done pulse.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between axi_lite_master and a slave or interconnect.
// The master modport drives the request channels and accepts responses.
interface axi_lite_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_awaddr;
  logic                m_awvalid;
  logic                m_awready;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wvalid;
  logic                m_wready;
  logic [1:0]          m_bresp;
  logic                m_bvalid;
  logic                m_bready;
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic                m_arready;
  logic [DATA_W-1:0]   m_rdata;
  logic [1:0]          m_rresp;
  logic                m_rvalid;
  logic                m_rready;

  modport master (
    output m_awaddr, m_awvalid, input m_awready,
    output m_wdata, m_wstrb, m_wvalid, input m_wready,
    input m_bresp, m_bvalid, output m_bready,
    output m_araddr, m_arvalid, input m_arready,
    input m_rdata, m_rresp, m_rvalid, output m_rready
  );

  modport slave (
    input m_awaddr, m_awvalid, output m_awready,
    input m_wdata, m_wstrb, m_wvalid, output m_wready,
    output m_bresp, m_bvalid, input m_bready,
    input m_araddr, m_arvalid, output m_arready,
    output m_rdata, m_rresp, m_rvalid, input m_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// AXI4-Lite master engine: command pulses in, complete AXI4-Lite write and
// read transactions out, on two fully independent paths.
// Optional hung-slave watchdog: define AXIL_MASTER_TIMEOUT_EN to enable it.
module axi_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start_write,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                w_busy,
  output logic                w_done,
  output logic                w_error,
  input  logic                start_read,
  input  logic [ADDR_W-1:0]   raddr,
  output logic                r_busy,
  output logic [DATA_W-1:0]   rdata,
  output logic                r_done,
  output logic                r_error,
  axi_lite_master_if.master   bus
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_badDataW
    $error("axi_lite_master: DATA_W must be 32 or 64");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_badTimeout
    $error("axi_lite_master: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DRAIN} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DRAIN} rState_t;
`else
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wState_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rState_t;
`endif

  wState_t r_wState, w_wNext;
  rState_t r_rState, w_rNext;

  logic                r_awSent, r_wSent;
  logic [ADDR_W-1:0]   r_awAddr, r_arAddr;
  logic [DATA_W-1:0]   r_wData, r_rData;
  logic [DATA_W/8-1:0] r_wStrb;
  logic                r_wDone, r_wError, r_rDone, r_rError;
  logic                w_awValid, w_wValid, w_bReady, w_arValid, w_rReady;
  logic                w_wBusy, w_rBusy;
  logic                w_awHs, w_wHs, w_bHs, w_arHs, w_rHs;

  assign w_awHs = w_awValid & bus.m_awready;
  assign w_wHs  = w_wValid  & bus.m_wready;
  assign w_bHs  = w_bReady  & bus.m_bvalid;
  assign w_arHs = w_arValid & bus.m_arready;
  assign w_rHs  = w_rReady  & bus.m_rvalid;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] r_wTimer, r_rTimer;
  logic               w_wTimeout, w_rTimeout;

  // A handshake on the expiry cycle counts as progress, so it wins over the timeout.
  assign w_wTimeout = (r_wState != W_IDLE) && !(w_awHs || w_wHs || w_bHs) && (r_wTimer == TIMER_LAST);
  assign w_rTimeout = (r_rState != R_IDLE) && !(w_arHs || w_rHs) && (r_rTimer == TIMER_LAST);

  // Write watchdog: restarts on every state change and every handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_wTimer <= '0;
    else if (r_wState == W_IDLE || w_wNext != r_wState || w_awHs || w_wHs || w_bHs) r_wTimer <= '0;
    else r_wTimer <= r_wTimer + 1'b1;
  end

  // Read watchdog: same rules as the write side.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rTimer <= '0;
    else if (r_rState == R_IDLE || w_rNext != r_rState || w_arHs || w_rHs) r_rTimer <= '0;
    else r_rTimer <= r_rTimer + 1'b1;
  end
`endif

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_wState <= W_IDLE;
    else          r_wState <= w_wNext;
  end

  // Write next state: AW and W may complete in either order before B is awaited.
  always_comb begin
    w_wNext = r_wState;
    case (r_wState)
      W_IDLE:  if (start_write) w_wNext = W_REQ;
      W_REQ: begin
        if ((r_awSent || w_awHs) && (r_wSent || w_wHs)) w_wNext = W_RESP;
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (w_wTimeout) w_wNext = W_DRAIN;
`endif
      end
      W_RESP: begin
        if (w_bHs) w_wNext = W_IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (w_wTimeout) w_wNext = W_DRAIN;
`endif
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      W_DRAIN: if (w_bHs || w_wTimeout) w_wNext = W_IDLE;
`endif
      default: w_wNext = W_IDLE;
    endcase
  end

  // Write outputs: each valid drops on its own handshake via the sent flags.
  always_comb begin
    w_awValid = 1'b0;
    w_wValid  = 1'b0;
    w_bReady  = 1'b0;
    w_wBusy   = (r_wState != W_IDLE);
    case (r_wState)
      W_REQ: begin
        w_awValid = !r_awSent;
        w_wValid  = !r_wSent;
      end
      W_RESP:  w_bReady = 1'b1;
`ifdef AXIL_MASTER_TIMEOUT_EN
      W_DRAIN: w_bReady = 1'b1;
`endif
      default: ;
    endcase
  end

  // Remember which write request channels have already handshaken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awSent <= 1'b0;
      r_wSent  <= 1'b0;
    end else if (r_wState == W_REQ) begin
      if (w_awHs) r_awSent <= 1'b1;
      if (w_wHs)  r_wSent  <= 1'b1;
    end else begin
      r_awSent <= 1'b0;
      r_wSent  <= 1'b0;
    end
  end

  // Capture write command; held until the next accepted command.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_awAddr <= '0;
      r_wData  <= '0;
      r_wStrb  <= '0;
    end else if (r_wState == W_IDLE && start_write) begin
      r_awAddr <= waddr;
      r_wData  <= wdata;
      r_wStrb  <= wstrb;
    end
  end

  // Write completion pulse; a drained stray response never produces one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wDone  <= 1'b0;
      r_wError <= 1'b0;
    end else begin
      r_wDone  <= 1'b0;
      r_wError <= 1'b0;
      if (r_wState == W_RESP && w_bHs) begin
        r_wDone  <= 1'b1;
        r_wError <= (bus.m_bresp != 2'b00);
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      else if (w_wTimeout && (r_wState == W_REQ || r_wState == W_RESP)) begin
        r_wDone  <= 1'b1;
        r_wError <= 1'b1;
      end
`endif
    end
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_rState <= R_IDLE;
    else          r_rState <= w_rNext;
  end

  // Read next state: address phase, then data phase.
  always_comb begin
    w_rNext = r_rState;
    case (r_rState)
      R_IDLE: if (start_read) w_rNext = R_ADDR;
      R_ADDR: begin
        if (w_arHs) w_rNext = R_DATA;
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (w_rTimeout) w_rNext = R_DRAIN;
`endif
      end
      R_DATA: begin
        if (w_rHs) w_rNext = R_IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
        else if (w_rTimeout) w_rNext = R_DRAIN;
`endif
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      R_DRAIN: if (w_rHs || w_rTimeout) w_rNext = R_IDLE;
`endif
      default: w_rNext = R_IDLE;
    endcase
  end

  // Read outputs decoded from state.
  always_comb begin
    w_arValid = 1'b0;
    w_rReady  = 1'b0;
    w_rBusy   = (r_rState != R_IDLE);
    case (r_rState)
      R_ADDR:  w_arValid = 1'b1;
      R_DATA:  w_rReady  = 1'b1;
`ifdef AXIL_MASTER_TIMEOUT_EN
      R_DRAIN: w_rReady  = 1'b1;
`endif
      default: ;
    endcase
  end

  // Capture read address on accept; latch read data only on a real R handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arAddr <= '0;
      r_rData  <= '0;
    end else begin
      if (r_rState == R_IDLE && start_read) r_arAddr <= raddr;
      if (r_rState == R_DATA && w_rHs)      r_rData  <= bus.m_rdata;
    end
  end

  // Read completion pulse; a drained stray response never produces one.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rDone  <= 1'b0;
      r_rError <= 1'b0;
    end else begin
      r_rDone  <= 1'b0;
      r_rError <= 1'b0;
      if (r_rState == R_DATA && w_rHs) begin
        r_rDone  <= 1'b1;
        r_rError <= (bus.m_rresp != 2'b00);
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      else if (w_rTimeout && (r_rState == R_ADDR || r_rState == R_DATA)) begin
        r_rDone  <= 1'b1;
        r_rError <= 1'b1;
      end
`endif
    end
  end

  assign bus.m_awaddr  = r_awAddr;
  assign bus.m_awvalid = w_awValid;
  assign bus.m_wdata   = r_wData;
  assign bus.m_wstrb   = r_wStrb;
  assign bus.m_wvalid  = w_wValid;
  assign bus.m_bready  = w_bReady;
  assign bus.m_araddr  = r_arAddr;
  assign bus.m_arvalid = w_arValid;
  assign bus.m_rready  = w_rReady;
  assign w_busy        = w_wBusy;
  assign w_done        = r_wDone;
  assign w_error       = r_wError;
  assign r_busy        = w_rBusy;
  assign rdata         = r_rData;
  assign r_done        = r_rDone;
  assign r_error       = r_rError;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: reactive slave model with configurable ready
// delays and responses, plus queues of expected transaction results.
module tb_axi_lite_master;

  localparam int TMO = 8;
  localparam int WAIT_LIMIT = 60;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        err;
  } wrExp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } rdExp_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        start_write = 1'b0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        w_busy, w_done, w_error;
  logic        start_read = 1'b0;
  logic [31:0] raddr = '0;
  logic        r_busy;
  logic [31:0] rdata;
  logic        r_done, r_error;

  axi_lite_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .start_write(start_write), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .w_busy(w_busy), .w_done(w_done), .w_error(w_error),
    .start_read(start_read), .raddr(raddr),
    .r_busy(r_busy), .rdata(rdata), .r_done(r_done), .r_error(r_error),
    .bus(bus)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad = 0;
  wrExp_t expWrQ[$];
  rdExp_t expRdQ[$];
  logic [31:0] modelRdata = '0;

  // slave configuration and observation
  int          cfgAwDelay = 0, cfgWDelay = 0, cfgArDelay = 0;
  logic [1:0]  cfgBresp = 2'b00, cfgRresp = 2'b00;
  logic [31:0] cfgRdata = '0;
  bit          injectR = 1'b0;
  logic [31:0] injectRdata = '0;
  int          awHsCnt = 0, wHsCnt = 0, bHsCnt = 0, arHsCnt = 0, rHsCnt = 0;
  logic [31:0] lastAwAddr = '0, lastWData = '0, lastArAddr = '0;
  logic [3:0]  lastWStrb = '0;
  int          awWait = 0, wWait = 0, arWait = 0;
  bit          awPend = 0, wPend = 0, bPend = 0, arPend = 0, rPend = 0, gotAw = 0, gotW = 0;

  // Slave model: decides readys/valids on the falling edge and predicts the
  // handshakes that the next rising edge will complete.
  always @(negedge aclk) begin
    if (!aresetn) begin
      bus.m_awready = 0; bus.m_wready = 0; bus.m_bvalid = 0; bus.m_bresp = 2'b00;
      bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rresp = 2'b00; bus.m_rdata = '0;
      awWait = 0; wWait = 0; arWait = 0;
      awPend = 0; wPend = 0; bPend = 0; arPend = 0; rPend = 0; gotAw = 0; gotW = 0;
    end else begin
      if (bPend) begin bus.m_bvalid = 0; bPend = 0; end
      if (rPend) begin bus.m_rvalid = 0; rPend = 0; end
      if (awPend) begin gotAw = 1; awPend = 0; end
      if (wPend) begin gotW = 1; wPend = 0; end
      if (arPend) begin
        arPend = 0; bus.m_rvalid = 1; bus.m_rdata = cfgRdata; bus.m_rresp = cfgRresp;
      end
      if (injectR && !bus.m_rvalid) begin
        bus.m_rvalid = 1; bus.m_rdata = injectRdata; bus.m_rresp = 2'b00; injectR = 0;
      end
      if (gotAw && gotW && !bus.m_bvalid) begin
        bus.m_bvalid = 1; bus.m_bresp = cfgBresp; gotAw = 0; gotW = 0;
      end
      if (bus.m_awvalid && awWait >= cfgAwDelay) bus.m_awready = 1;
      else begin bus.m_awready = 0; awWait = bus.m_awvalid ? awWait + 1 : 0; end
      if (bus.m_wvalid && wWait >= cfgWDelay) bus.m_wready = 1;
      else begin bus.m_wready = 0; wWait = bus.m_wvalid ? wWait + 1 : 0; end
      if (bus.m_arvalid && arWait >= cfgArDelay) bus.m_arready = 1;
      else begin bus.m_arready = 0; arWait = bus.m_arvalid ? arWait + 1 : 0; end
      awPend = bus.m_awvalid && bus.m_awready;
      wPend  = bus.m_wvalid && bus.m_wready;
      arPend = bus.m_arvalid && bus.m_arready;
      bPend  = bus.m_bvalid && bus.m_bready;
      rPend  = bus.m_rvalid && bus.m_rready;
      if (awPend) begin awHsCnt++; lastAwAddr = bus.m_awaddr; awWait = 0; end
      if (wPend) begin wHsCnt++; lastWData = bus.m_wdata; lastWStrb = bus.m_wstrb; wWait = 0; end
      if (arPend) begin arHsCnt++; lastArAddr = bus.m_araddr; arWait = 0; end
      if (bPend) bHsCnt++;
      if (rPend) rHsCnt++;
    end
  end

  // Drive a write command (call at a falling edge); the expectation is queued now.
  task automatic issueWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wrExp_t e;
    e.addr = a; e.data = d; e.strb = s; e.err = (cfgBresp != 2'b00);
    expWrQ.push_back(e);
    waddr = a; wdata = d; wstrb = s; start_write = 1'b1;
  endtask

  task automatic issueRead(input logic [31:0] a, input logic expErr);
    rdExp_t e;
    e.addr = a; e.err = expErr;
    e.data = expErr ? modelRdata : cfgRdata;
    if (!expErr) modelRdata = cfgRdata;
    expRdQ.push_back(e);
    raddr = a; start_read = 1'b1;
  endtask

  task automatic releaseStarts();
    @(posedge aclk);
    #1;
    start_write = 1'b0;
    start_read  = 1'b0;
  endtask

  // Count falling edges until the given done pulse is seen, bounded.
  task automatic waitDone(input bit isRead, output int n, output bit ok);
    n = 0; ok = 0;
    while (n < WAIT_LIMIT && !ok) begin
      @(negedge aclk);
      n++;
      if (isRead ? r_done : w_done) ok = 1;
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    total++; if (bus.m_awvalid !== 1'b0 || bus.m_wvalid !== 1'b0 || bus.m_arvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valids got aw=%b w=%b ar=%b want 0", bus.m_awvalid, bus.m_wvalid, bus.m_arvalid); end
    total++; if (bus.m_bready !== 1'b0 || bus.m_rready !== 1'b0) begin bad++; $display("[TB] FAIL rst_readys got b=%b r=%b want 0", bus.m_bready, bus.m_rready); end
    total++; if ({w_busy, w_done, w_error, r_busy, r_done, r_error} !== 6'b0) begin bad++; $display("[TB] FAIL rst_status got %b want 000000", {w_busy, w_done, w_error, r_busy, r_done, r_error}); end
    total++; if (bus.m_awaddr !== 32'h0 || bus.m_wdata !== 32'h0 || bus.m_wstrb !== 4'h0 || bus.m_araddr !== 32'h0) begin bad++; $display("[TB] FAIL rst_regs got awaddr=%h wdata=%h wstrb=%h araddr=%h want 0", bus.m_awaddr, bus.m_wdata, bus.m_wstrb, bus.m_araddr); end
    total++; if (rdata !== 32'h0) begin bad++; $display("[TB] FAIL rst_rdata got %h want 0", rdata); end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_zero_wait_write();
    int n; bit ok; wrExp_t e;
    issueWrite(32'h10, 32'hDEADBEEF, 4'hF);
    @(posedge aclk); #1; start_write = 1'b0;
    total++; if (bus.m_awvalid !== 1'b1 || bus.m_wvalid !== 1'b1) begin bad++; $display("[TB] FAIL zw_valids got aw=%b w=%b want 1 1", bus.m_awvalid, bus.m_wvalid); end
    waitDone(1'b0, n, ok);
    total++; if (!ok || n !== 3) begin bad++; $display("[TB] FAIL zw_latency got %0d (seen=%0d) want 3", n, ok); end
    total++; if (expWrQ.size() != 1) begin bad++; $display("[TB] FAIL zw_queue got %0d want 1", expWrQ.size()); end
    else begin
      e = expWrQ.pop_front();
      total++; if (lastAwAddr !== e.addr || lastWData !== e.data || lastWStrb !== e.strb) begin bad++; $display("[TB] FAIL zw_bus got %h/%h/%h want %h/%h/%h", lastAwAddr, lastWData, lastWStrb, e.addr, e.data, e.strb); end
      total++; if (w_error !== e.err) begin bad++; $display("[TB] FAIL zw_err got %b want %b", w_error, e.err); end
    end
    total++; if (w_busy !== 1'b0) begin bad++; $display("[TB] FAIL zw_busy got %b want 0", w_busy); end
  endtask

  task automatic test_back_to_back();
    int n; bit ok; wrExp_t e;
    issueWrite(32'h14, 32'hCAFEF00D, 4'h3);
    releaseStarts();
    waitDone(1'b0, n, ok);
    total++; if (!ok || n !== 3) begin bad++; $display("[TB] FAIL b2b_latency1 got %0d want 3", n); end
    // next command on the same falling edge where done is high
    issueWrite(32'h18, 32'h0BADCAFE, 4'hC);
    releaseStarts();
    waitDone(1'b0, n, ok);
    total++; if (!ok || n !== 3) begin bad++; $display("[TB] FAIL b2b_latency2 got %0d want 3", n); end
    e = expWrQ.pop_front();
    e = expWrQ.pop_front();
    total++; if (lastAwAddr !== e.addr || lastWData !== e.data || lastWStrb !== e.strb) begin bad++; $display("[TB] FAIL b2b_bus got %h/%h/%h want %h/%h/%h", lastAwAddr, lastWData, lastWStrb, e.addr, e.data, e.strb); end
    @(negedge aclk);
  endtask

  task automatic test_delayed_aw();
    int n; bit ok; wrExp_t e; int awBefore;
    awBefore = awHsCnt;
    cfgAwDelay = 3; cfgBresp = 2'b10;
    issueWrite(32'h20, 32'h11223344, 4'h5);
    releaseStarts();
    @(negedge aclk); @(negedge aclk);
    total++; if (bus.m_wvalid !== 1'b0 || bus.m_awvalid !== 1'b1) begin bad++; $display("[TB] FAIL dly_order got aw=%b w=%b want 1 0", bus.m_awvalid, bus.m_wvalid); end
    waitDone(1'b0, n, ok);
    total++; if (!ok || n + 2 !== 3 + cfgAwDelay) begin bad++; $display("[TB] FAIL dly_latency got %0d want %0d", n + 2, 3 + cfgAwDelay); end
    e = expWrQ.pop_front();
    total++; if (w_error !== e.err) begin bad++; $display("[TB] FAIL dly_err got %b want %b", w_error, e.err); end
    total++; if (awHsCnt - awBefore !== 1 || lastAwAddr !== e.addr) begin bad++; $display("[TB] FAIL dly_aw got cnt=%0d addr=%h want 1 %h", awHsCnt - awBefore, lastAwAddr, e.addr); end
    cfgAwDelay = 0; cfgBresp = 2'b00;
    @(negedge aclk);
  endtask

  task automatic test_concurrent();
    int n; bit wSeen, rSeen; wrExp_t we; rdExp_t re; int awBefore, arBefore;
    awBefore = awHsCnt; arBefore = arHsCnt;
    cfgRdata = 32'h12345678; cfgRresp = 2'b00;
    issueWrite(32'h30, 32'hA5A5A5A5, 4'hF);
    issueRead(32'h34, 1'b0);
    releaseStarts();
    n = 0; wSeen = 0; rSeen = 0;
    while (n < WAIT_LIMIT && !(wSeen && rSeen)) begin
      @(negedge aclk); n++;
      if (w_done) begin
        wSeen = 1; we = expWrQ.pop_front();
        total++; if (w_error !== we.err || lastWData !== we.data || lastAwAddr !== we.addr) begin bad++; $display("[TB] FAIL cc_write got err=%b data=%h addr=%h want %b %h %h", w_error, lastWData, lastAwAddr, we.err, we.data, we.addr); end
      end
      if (r_done) begin
        rSeen = 1; re = expRdQ.pop_front();
        total++; if (rdata !== re.data || r_error !== re.err) begin bad++; $display("[TB] FAIL cc_read got data=%h err=%b want %h %b", rdata, r_error, re.data, re.err); end
        total++; if (lastArAddr !== re.addr) begin bad++; $display("[TB] FAIL cc_araddr got %h want %h", lastArAddr, re.addr); end
      end
    end
    total++; if (!(wSeen && rSeen) || n !== 3) begin bad++; $display("[TB] FAIL cc_done got w=%b r=%b n=%0d want both at 3", wSeen, rSeen, n); end
    total++; if (awHsCnt - awBefore !== 1 || arHsCnt - arBefore !== 1) begin bad++; $display("[TB] FAIL cc_hscount got aw=%0d ar=%0d want 1 1", awHsCnt - awBefore, arHsCnt - arBefore); end
    @(negedge aclk);
  endtask

  task automatic test_read_busy_ignore();
    int n; bit ok; rdExp_t re; int arBefore, dones;
    arBefore = arHsCnt;
    cfgArDelay = 2; cfgRdata = 32'h0F0E0D0C; cfgRresp = 2'b11;
    issueRead(32'h40, 1'b1);
    expRdQ[0].data = 32'h0F0E0D0C;
    modelRdata = 32'h0F0E0D0C;
    releaseStarts();
    @(negedge aclk);
    raddr = 32'h80; start_read = 1'b1;
    releaseStarts();
    waitDone(1'b1, n, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL busy_done got none want r_done"); end
    re = expRdQ.pop_front();
    total++; if (rdata !== re.data || r_error !== 1'b1) begin bad++; $display("[TB] FAIL busy_read got data=%h err=%b want %h 1", rdata, r_error, re.data); end
    dones = 0;
    repeat (6) begin @(negedge aclk); if (r_done) dones++; end
    total++; if (dones !== 0 || r_busy !== 1'b0) begin bad++; $display("[TB] FAIL busy_extra got dones=%0d busy=%b want 0 0", dones, r_busy); end
    total++; if (arHsCnt - arBefore !== 1 || lastArAddr !== re.addr) begin bad++; $display("[TB] FAIL busy_ar got cnt=%0d addr=%h want 1 %h", arHsCnt - arBefore, lastArAddr, re.addr); end
    cfgArDelay = 0; cfgRresp = 2'b00;
  endtask

  task automatic test_reset_abort();
    int n; bit ok; int dones; wrExp_t e;
    waddr = 32'h50; wdata = 32'h55555555; wstrb = 4'hF; start_write = 1'b1;
    releaseStarts();
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    total++; if (w_busy !== 1'b0 || bus.m_bready !== 1'b0 || w_done !== 1'b0) begin bad++; $display("[TB] FAIL abort_status got busy=%b bready=%b done=%b want 0", w_busy, bus.m_bready, w_done); end
    total++; if (bus.m_awaddr !== 32'h0 || bus.m_wdata !== 32'h0 || rdata !== 32'h0) begin bad++; $display("[TB] FAIL abort_regs got awaddr=%h wdata=%h rdata=%h want 0", bus.m_awaddr, bus.m_wdata, rdata); end
    modelRdata = '0;
    dones = 0;
    repeat (3) begin @(negedge aclk); if (w_done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("[TB] FAIL abort_done got %0d want 0", dones); end
    aresetn = 1'b1;
    @(negedge aclk);
    issueWrite(32'h60, 32'h76543210, 4'h9);
    releaseStarts();
    waitDone(1'b0, n, ok);
    e = expWrQ.pop_front();
    total++; if (!ok || n !== 3 || w_error !== e.err || lastWData !== e.data || lastWStrb !== e.strb) begin bad++; $display("[TB] FAIL abort_fresh got n=%0d err=%b data=%h strb=%h want 3 %b %h %h", n, w_error, lastWData, lastWStrb, e.err, e.data, e.strb); end
    @(negedge aclk);
  endtask

`ifdef AXIL_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit ok; rdExp_t re; int arBefore, rBefore, dones;
    arBefore = arHsCnt; rBefore = rHsCnt;
    cfgArDelay = 1000000;
    issueRead(32'h100, 1'b1);
    releaseStarts();
    waitDone(1'b1, n, ok);
    re = expRdQ.pop_front();
    total++; if (!ok || n !== TMO + 1) begin bad++; $display("[TB] FAIL tmo_latency got %0d want %0d", n, TMO + 1); end
    total++; if (r_error !== 1'b1 || r_busy !== 1'b1 || arHsCnt - arBefore !== 0) begin bad++; $display("[TB] FAIL tmo_state got err=%b busy=%b ar=%0d want 1 1 0", r_error, r_busy, arHsCnt - arBefore); end
    injectRdata = 32'hBAD0BAD0; injectR = 1'b1;
    dones = 0;
    repeat (5) begin @(negedge aclk); if (r_done) dones++; end
    total++; if (dones !== 0 || r_busy !== 1'b0 || rHsCnt - rBefore !== 1) begin bad++; $display("[TB] FAIL tmo_drain got dones=%0d busy=%b rhs=%0d want 0 0 1", dones, r_busy, rHsCnt - rBefore); end
    total++; if (rdata !== re.data) begin bad++; $display("[TB] FAIL tmo_rdata got %h want %h", rdata, re.data); end
    cfgArDelay = 0;
  endtask
`endif

  initial begin
    $display("[TB] axi_lite_master bench start");
    test_reset();
    test_zero_wait_write();
    test_back_to_back();
    test_delayed_aw();
    test_concurrent();
    test_read_busy_ignore();
    test_reset_abort();
`ifdef AXIL_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
